// File: rtl/rr_arb_pkg.sv
// Shared types and defaults for the round-robin one-hot arbiter.
// Optional RR_ARBITER_GRANT_IDX_EN feature lives in the top; nothing here depends on it.
package rr_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_MAX_HOLD = 8;

    // Pointer width; a 1-bit floor keeps degenerate sizes from producing zero-width vectors.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick_first.sv
// Rotating-priority search: returns the first set bit of (req & ~excl)
// starting at ptr and wrapping, as a one-hot vector (all zero if none).
module rr_pick_first #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    input  logic [NUM_REQ-1:0] i_excl,
    output logic [NUM_REQ-1:0] o_onehot
);

    logic [NUM_REQ-1:0] w_cand;
    logic [PTR_W-1:0]   w_idx;
    logic               w_found;

    always_comb begin
        w_cand   = i_req & ~i_excl;
        o_onehot = '0;
        w_found  = 1'b0;
        w_idx    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // NUM_REQ is a power of two, so the add wraps modulo NUM_REQ for free.
            w_idx = i_ptr + PTR_W'(i);
            if (!w_found && w_cand[w_idx]) begin
                o_onehot[w_idx] = 1'b1;
                w_found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter_onehot.sv
// Round-robin arbiter with registered one-hot grant and bounded hold time.
// Define RR_ARBITER_GRANT_IDX_EN to add the registered binary grant_idx output.
module rr_arbiter_onehot
    import rr_arb_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    output logic [NUM_REQ-1:0]          grant,
    output logic                        grant_valid,
`ifdef RR_ARBITER_GRANT_IDX_EN
    output logic [ptr_w(NUM_REQ)-1:0]   grant_idx,
`endif
    output logic                        busy
);

    localparam int PTR_W  = ptr_w(NUM_REQ);
    localparam int HCNT_W = $clog2(MAX_HOLD + 1);

    if (NUM_REQ < 2 || (NUM_REQ & (NUM_REQ - 1)) != 0) begin : g_chk_n
        $error("NUM_REQ must be a power of two and at least 2");
    end
    if (MAX_HOLD < 1) begin : g_chk_h
        $error("MAX_HOLD must be at least 1");
    end

    arb_state_t          r_state, w_state_nxt;
    logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
    logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
    logic [HCNT_W-1:0]   r_hcnt, w_hcnt_nxt;

    logic [PTR_W-1:0]    w_owner;
    logic [PTR_W-1:0]    w_pick_ptr;
    logic [NUM_REQ-1:0]  w_pick_excl;
    logic [NUM_REQ-1:0]  w_pick;
    logic                w_own_req;
    logic                w_others;
    logic                w_hold_max;

    always_comb begin
        w_owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant[i]) w_owner = PTR_W'(i);
        end
    end

    // One picker serves all three cases: from r_ptr when idle, from owner+1
    // excluding the owner when granted (the exclusion is harmless on release).
    assign w_pick_ptr  = (r_state == GRANTED) ? w_owner + PTR_W'(1) : r_ptr;
    assign w_pick_excl = (r_state == GRANTED) ? r_grant : '0;

    rr_pick_first #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (w_pick_ptr),
        .i_excl   (w_pick_excl),
        .o_onehot (w_pick)
    );

    assign w_own_req  = |(req & r_grant);
    assign w_others   = |(req & ~r_grant);
    assign w_hold_max = (r_hcnt == HCNT_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        w_hcnt_nxt  = r_hcnt;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    w_state_nxt = GRANTED;
                    w_grant_nxt = w_pick;
                    w_hcnt_nxt  = HCNT_W'(1);
                end
            end
            GRANTED: begin
                // Release and preempt share a path: advance past the owner and re-pick.
                if (!w_own_req || (w_hold_max && w_others)) begin
                    w_ptr_nxt = w_pick_ptr;
                    if (|w_pick) begin
                        w_grant_nxt = w_pick;
                        w_hcnt_nxt  = HCNT_W'(1);
                    end else begin
                        w_state_nxt = IDLE;
                        w_grant_nxt = '0;
                        w_hcnt_nxt  = '0;
                    end
                end else if (!w_hold_max) begin
                    w_hcnt_nxt = r_hcnt + HCNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
                w_hcnt_nxt  = '0;
            end
        endcase
    end

    always_comb begin
        grant       = r_grant;
        grant_valid = |r_grant;
        busy        = (r_state == GRANTED);
    end

`ifdef RR_ARBITER_GRANT_IDX_EN
    logic [PTR_W-1:0] r_grant_idx;
    logic [PTR_W-1:0] w_idx_nxt;

    always_comb begin
        w_idx_nxt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_nxt[i]) w_idx_nxt = PTR_W'(i);
        end
    end

    // Only load on a real grant so the index holds its last value while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_idx <= '0;
        end else if (|w_grant_nxt) begin
            r_grant_idx <= w_idx_nxt;
        end
    end

    assign grant_idx = r_grant_idx;
`endif

endmodule
